// File: rtl/krake_wb_pkg.sv
// Shared definitions for the krake Wishbone-style interconnect: FSM encoding,
// default widths and the saturating error-count helper.
package krake_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_NSLV    = 12;
  localparam int DEF_ADR_W   = 8;
  localparam int DEF_DAT_W   = 8;
  localparam int DEF_SEL_W   = 4;
  localparam int DEF_TIMEOUT = 15;
  localparam int CNT_W       = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/krake_wb_watchdog.sv
// BUSY-cycle watchdog: counts while run is high, cleared whenever clear is high.
// expired is asserted combinationally during the TIMEOUT-th consecutive run cycle.
module krake_wb_watchdog
  import krake_wb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  // r_cnt holds the number of run cycles already completed, so the current
  // cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
  assign o_expired = i_run && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/krake_wb_intercon.sv
// Single-master to NSLV-slot Wishbone-style intercon with unmapped-slot error reporting.
// Optional BUSY watchdog enabled by defining INTERCON_TIMEOUT_EN.
module krake_wb_intercon
  import krake_wb_pkg::*;
#(
  parameter int NSLV    = DEF_NSLV,
  parameter int ADR_W   = DEF_ADR_W,
  parameter int DAT_W   = DEF_DAT_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m_stb_i,
  input  logic                    m_we_i,
  input  logic [ADR_W-1:0]        m_adr_i,
  input  logic [DAT_W-1:0]        m_dat_i,
  output logic [DAT_W-1:0]        m_dat_o,
  output logic                    m_ack_o,
  output logic                    m_err_o,
  input  logic [NSLV-1:0]         slot_en_i,
  output logic [NSLV-1:0]         s_stb_o,
  output logic                    s_we_o,
  output logic [ADR_W-SEL_W-1:0]  s_adr_o,
  output logic [DAT_W-1:0]        s_dat_o,
  input  logic [NSLV*DAT_W-1:0]   s_dat_i,
  input  logic [NSLV-1:0]         s_ack_i,
  output logic [CNT_W-1:0]        err_cnt_o
);

  localparam int LADR_W = ADR_W - SEL_W;
  localparam int NSLOT  = 1 << SEL_W;

  state_t              r_state;
  state_t              w_next;
  logic [SEL_W-1:0]    r_slot;
  logic                r_we;
  logic [LADR_W-1:0]   r_adr;
  logic [DAT_W-1:0]    r_wdat;
  logic [DAT_W-1:0]    r_rdat;
  logic                r_ack;
  logic [CNT_W-1:0]    r_err_cnt;

  logic [SEL_W-1:0]    w_slot;
  logic [NSLOT-1:0]    w_en_ext;
  logic [NSLOT-1:0]    w_ack_ext;
  logic                w_slot_ok;
  logic                w_sel_ack;
  logic                w_capture;
  logic                w_expired;
  logic [DAT_W-1:0]    w_rdat;
  logic [NSLV-1:0]     w_stb;

  // Slots at or beyond NSLV read as disabled after zero-extension, so one
  // lookup covers both the range check and the per-slot enable.
  assign w_slot    = m_adr_i[ADR_W-1 -: SEL_W];
  assign w_en_ext  = NSLOT'(slot_en_i);
  assign w_ack_ext = NSLOT'(s_ack_i);
  assign w_slot_ok = w_en_ext[w_slot];
  assign w_sel_ack = w_ack_ext[r_slot];
  assign w_capture = (r_state == BUSY) && m_stb_i && w_sel_ack;

`ifdef INTERCON_TIMEOUT_EN
  krake_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_clear   (r_state != BUSY),
    .i_run     (r_state == BUSY),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_rdat = '0;
    w_stb  = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (r_slot == SEL_W'(k)) begin
        w_rdat   = s_dat_i[k*DAT_W +: DAT_W];
        w_stb[k] = (r_state == BUSY);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobe removal wins over a same-cycle ack: the master has abandoned the cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (m_stb_i) w_next = w_slot_ok ? BUSY : ERR;
      BUSY: begin
        if (!m_stb_i)       w_next = IDLE;
        else if (w_sel_ack) w_next = DONE;
        else if (w_expired) w_next = ERR;
      end
      ERR:  w_next = DONE;
      DONE: if (!m_stb_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_slot    <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_rdat    <= '0;
      r_ack     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_ack <= w_capture;
      if (r_state == IDLE && m_stb_i) begin
        r_slot <= w_slot;
        r_we   <= m_we_i;
        r_adr  <= m_adr_i[LADR_W-1:0];
        r_wdat <= m_dat_i;
      end
      if (w_capture && !r_we) begin
        r_rdat <= w_rdat;
      end
      if (r_state == ERR) begin
        r_err_cnt <= sat_inc(r_err_cnt);
      end
    end
  end

  assign s_stb_o   = w_stb;
  assign s_we_o    = r_we;
  assign s_adr_o   = r_adr;
  assign s_dat_o   = r_wdat;
  assign m_dat_o   = r_rdat;
  assign m_ack_o   = r_ack;
  assign m_err_o   = (r_state == ERR);
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_krake_wb_intercon.sv
// Scoreboard bench for krake_wb_intercon: directed cases plus randomized transactions.
// Expected ack/err responses are queued at issue and checked by an independent monitor.
module tb_krake_wb_intercon;

  localparam int NSLV = 12;
  localparam int TO   = 15;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          m_stb_i = 1'b0;
  logic          m_we_i = 1'b0;
  logic [7:0]    m_adr_i = '0;
  logic [7:0]    m_dat_i = '0;
  logic [7:0]    m_dat_o;
  logic          m_ack_o;
  logic          m_err_o;
  logic [11:0]   slot_en_i = 12'hFFF;
  logic [11:0]   s_stb_o;
  logic          s_we_o;
  logic [3:0]    s_adr_o;
  logic [7:0]    s_dat_o;
  logic [95:0]   s_dat_i = '0;
  logic [11:0]   s_ack_i = '0;
  logic [7:0]    err_cnt_o;

  krake_wb_intercon #(
    .NSLV(NSLV), .ADR_W(8), .DAT_W(8), .SEL_W(4), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .slot_en_i(slot_en_i), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       err;
    logic [7:0] dat;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [7:0] model_dat = '0;
  int         model_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Monitor: every ack/err pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (m_ack_o || m_err_o) begin
      exp_t e;
      chk("ack_err_exclusive", {31'd0, m_ack_o & m_err_o}, 32'd0);
      chk("resp_expected", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("resp_kind_err", {31'd0, m_err_o}, {31'd0, e.err});
        chk("m_dat_o", {24'd0, m_dat_o}, {24'd0, e.dat});
      end
    end
  end

  // mode: 0 normal, 1 master abort after k cycles, 2 reset after k cycles, 3 silent slave
  task automatic run_txn(input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                         input logic [7:0] rdat, input int d, input int hold,
                         input int mode_in, input int k);
    int          s;
    int          mode;
    int          n;
    logic        valid;
    logic        is_err;
    logic        push;
    logic        seen;
    logic [11:0] oh;
    logic [95:0] dvec;
    exp_t        e;

    mode  = mode_in;
    s     = int'(adr[7:4]);
    valid = (s < NSLV) && (((slot_en_i >> s) & 12'd1) != 12'd0);
    oh    = valid ? (12'd1 << s) : 12'd0;
    dvec  = {$urandom, $urandom, $urandom};
    if (valid) dvec[s*8 +: 8] = rdat;
    if (!valid) mode = 0;
`ifdef INTERCON_TIMEOUT_EN
    is_err = !valid || (mode == 3);
`else
    is_err = !valid;
`endif
    push = (mode == 0) || is_err;
    if (push) begin
      if (!is_err && !we) model_dat = rdat;
      if (is_err && model_err < 255) model_err++;
      e.err = is_err;
      e.dat = model_dat;
      q.push_back(e);
    end

    m_stb_i = 1'b1; m_we_i = we; m_adr_i = adr; m_dat_i = wdat;
    s_dat_i = dvec; s_ack_i = '0;
    tick();
    chk("s_stb_o_first", {20'd0, s_stb_o}, {20'd0, oh});
    if (valid) begin
      chk("s_adr_o", {28'd0, s_adr_o}, {28'd0, adr[3:0]});
      chk("s_dat_o", {24'd0, s_dat_o}, {24'd0, wdat});
      chk("s_we_o", {31'd0, s_we_o}, {31'd0, we});
    end

    case (mode)
      0: if (valid) begin
        for (int i = 0; i < d; i++) begin
          s_ack_i = 12'($urandom) & ~oh;
          tick();
        end
        s_ack_i = oh;
        tick();
        s_ack_i = '0;
        chk("s_stb_drop_on_ack", {20'd0, s_stb_o}, 32'd0);
      end
      1: begin
        repeat (k) tick();
        m_stb_i = 1'b0;
        tick();
        chk("s_stb_drop_abort", {20'd0, s_stb_o}, 32'd0);
        tick();
      end
      2: begin
        repeat (k) tick();
        m_stb_i = 1'b0;
        rst_i = 1'b1;
        tick();
        chk("rst_s_stb_o", {20'd0, s_stb_o}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
        chk("rst_m_dat_o", {24'd0, m_dat_o}, 32'd0);
        chk("rst_m_ack_o", {31'd0, m_ack_o}, 32'd0);
        rst_i = 1'b0;
        model_dat = '0;
        model_err = 0;
        tick();
      end
      default: begin
`ifdef INTERCON_TIMEOUT_EN
        n = 0;
        while (s_stb_o != 12'd0 && n < 100) begin
          n++;
          tick();
        end
        chk("timeout_stb_cycles", n, TO);
`else
        repeat (100) tick();
        chk("stb_still_high", {20'd0, s_stb_o}, {20'd0, oh});
        m_stb_i = 1'b0;
        tick();
        chk("s_stb_drop_abort", {20'd0, s_stb_o}, 32'd0);
        tick();
`endif
      end
    endcase

    if (push) begin
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        if (m_ack_o || m_err_o) seen = 1'b1;
        else tick();
      end
      chk("resp_seen", {31'd0, seen}, 32'd1);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("no_restart_while_held", {20'd0, s_stb_o}, 32'd0);
      end
      m_stb_i = 1'b0;
      tick();
      tick();
      chk("err_cnt_o", {24'd0, err_cnt_o}, model_err);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    tick(); tick();
    chk("reset_m_ack_o", {31'd0, m_ack_o}, 32'd0);
    chk("reset_m_err_o", {31'd0, m_err_o}, 32'd0);
    chk("reset_s_stb_o", {20'd0, s_stb_o}, 32'd0);
    chk("reset_m_dat_o", {24'd0, m_dat_o}, 32'd0);
    chk("reset_s_adr_o", {28'd0, s_adr_o}, 32'd0);
    chk("reset_s_dat_o", {24'd0, s_dat_o}, 32'd0);
    chk("reset_s_we_o", {31'd0, s_we_o}, 32'd0);
    chk("reset_err_cnt_o", {24'd0, err_cnt_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // Unmapped slot beyond NSLV, then a disabled in-range slot.
    run_txn(1'b0, 8'hE0, 8'h00, 8'h00, 0, 0, 0, 0);
    slot_en_i = 12'hFFF & ~12'h004;
    run_txn(1'b0, 8'h20, 8'h00, 8'h00, 0, 0, 0, 0);
    slot_en_i = 12'hFFF;

    run_txn(1'b0, 8'h35, 8'h00, 8'hA5, 2, 0, 0, 0);
    run_txn(1'b1, 8'h81, 8'h5A, 8'h33, 1, 0, 0, 0);
    run_txn(1'b0, 8'h47, 8'h00, 8'h3C, 1, 10, 0, 0);
    run_txn(1'b0, 8'h12, 8'h00, 8'h77, 0, 0, 3, 0);
    run_txn(1'b0, 8'h6A, 8'h00, 8'h11, 0, 0, 1, 2);

    for (int i = 0; i < 40; i++) begin
      logic       we;
      logic [7:0] adr;
      int         mode;
      slot_en_i = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'hFFF;
      we   = 1'($urandom);
      adr  = 8'($urandom);
      mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
      run_txn(we, adr, 8'($urandom), 8'($urandom), $urandom_range(0, 6),
              $urandom_range(0, 3), mode, $urandom_range(0, 4));
    end
    slot_en_i = 12'hFFF;

    run_txn(1'b0, 8'h9C, 8'h00, 8'h00, 0, 0, 2, 2);
    for (int i = 0; i < 256; i++) begin
      run_txn(1'b0, 8'hF0, 8'h00, 8'h00, 0, 0, 0, 0);
    end
    chk("err_cnt_saturated", {24'd0, err_cnt_o}, 32'd255);

    repeat (5) tick();
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
